// File: rtl/max7219_pkg.sv
// Purpose: shared constants for the MAX7219 serial frame receiver (register map, frame layout).
// Latency: n/a (constants and a pure helper function only).
// Backpressure: n/a.
package max7219_pkg;

  // Frame layout: bits[15:12] don't-care, bits[11:8] register address, bits[7:0] data.
  localparam int FRAME_BITS = 16;
  localparam int ADDR_LSB   = 8;
  localparam int ADDR_W     = 4;
  localparam int DATA_LSB   = 0;
  localparam int DATA_W     = 8;

  // MAX7219 register map.
  localparam logic [3:0] ADDR_NOOP         = 4'h0;
  localparam logic [3:0] ADDR_DIGIT0       = 4'h1;
  localparam logic [3:0] ADDR_DIGIT1       = 4'h2;
  localparam logic [3:0] ADDR_DIGIT2       = 4'h3;
  localparam logic [3:0] ADDR_DIGIT3       = 4'h4;
  localparam logic [3:0] ADDR_DIGIT4       = 4'h5;
  localparam logic [3:0] ADDR_DIGIT5       = 4'h6;
  localparam logic [3:0] ADDR_DIGIT6       = 4'h7;
  localparam logic [3:0] ADDR_DIGIT7       = 4'h8;
  localparam logic [3:0] ADDR_DECODE       = 4'h9;
  localparam logic [3:0] ADDR_INTENSITY    = 4'hA;
  localparam logic [3:0] ADDR_SCAN_LIMIT   = 4'hB;
  localparam logic [3:0] ADDR_SHUTDOWN     = 4'hC;
  localparam logic [3:0] ADDR_DISPLAY_TEST = 4'hF;

  // The no-op address and the two unmapped addresses (0xD, 0xE) have no backing register.
  function automatic logic shadow_writable(input logic [3:0] addr);
    return !((addr == ADDR_NOOP) || (addr == 4'hD) || (addr == 4'hE));
  endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Purpose: synchronise one async line into clk and produce a one-cycle rising-edge pulse.
// Latency: rise pulse and lvl change SYNC_STAGES+1 clk edges after the pin changes.
// Backpressure: none; the line is sampled every cycle.
// Ports: clk, rst (sync, active-high), din (async pin), lvl (synced level aligned with rise),
//        rise (one-cycle pulse on a 0->1 transition of the synced line).
module sync_edge_detect #(
  parameter int SYNC_STAGES = 2,   // minimum 2
  parameter bit RESET_VAL   = 1'b0 // idle level of the line
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic lvl,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic                   rise_q;

  // Synchroniser and history both reset to the idle level, so a line sitting at its
  // idle level when reset releases never produces a spurious edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
      hist_q <= RESET_VAL;
      rise_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      hist_q <= sync_q[SYNC_STAGES-1];
      rise_q <= sync_q[SYNC_STAGES-1] & ~hist_q;
    end
  end

  // hist_q and rise_q update on the same edge, so lvl is already 1 in the rise cycle.
  assign lvl  = hist_q;
  assign rise = rise_q;

endmodule

// File: rtl/max7219_frame_receiver.sv
// Purpose: MAX7219-style receiver; shifts DIN on CLK rise while LOAD low, latches last 16 bits on LOAD rise.
// Latency: frame_valid/frame_err pulse SYNC_STAGES+2 clk cycles after the spi_load pin rises.
// Backpressure: none; frames arrive at line rate and results are one-cycle pulses.
// Ports: clk, rst (sync, active-high); spi_clk/spi_din/spi_load (async serial link);
//        spi_dout (daisy-chain out); frame_valid/frame_err pulses; frame_addr/frame_data (last good frame);
//        rd_addr/rd_data (shadow register read port).
// Build option: define MAX7219_SHADOW_EN to add the 16x8 shadow register file behind rd_addr/rd_data;
//        without it rd_data is tied to 0.
module max7219_frame_receiver
  import max7219_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FRAME_BITS  = max7219_pkg::FRAME_BITS
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       spi_clk,
  input  logic       spi_din,
  input  logic       spi_load,
  output logic       spi_dout,
  output logic       frame_valid,
  output logic       frame_err,
  output logic [3:0] frame_addr,
  output logic [7:0] frame_data,
  input  logic [3:0] rd_addr,
  output logic [7:0] rd_data
);

  logic                   unused_clk_lvl;
  logic                   clk_rise;
  logic                   load_lvl;
  logic                   load_rise;
  logic [SYNC_STAGES-1:0] din_q;
  logic                   din_sync;

  logic [FRAME_BITS-1:0]  shift_q;
  logic [4:0]             bit_cnt_q;
  logic                   capture_ok;
  logic [3:0]             cap_addr;
  logic [7:0]             cap_data;

  sync_edge_detect #(
    .SYNC_STAGES (SYNC_STAGES),
    .RESET_VAL   (1'b0)
  ) u_clk_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (spi_clk),
    .lvl  (unused_clk_lvl),
    .rise (clk_rise)
  );

  sync_edge_detect #(
    .SYNC_STAGES (SYNC_STAGES),
    .RESET_VAL   (1'b1)
  ) u_load_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (spi_load),
    .lvl  (load_lvl),
    .rise (load_rise)
  );

  // Data needs no edge detect; it is stable for the whole clk-high phase of the link.
  always_ff @(posedge clk) begin
    if (rst) begin
      din_q <= '0;
    end else begin
      din_q <= {din_q[SYNC_STAGES-2:0], spi_din};
    end
  end
  assign din_sync = din_q[SYNC_STAGES-1];

  // Capture always looks at the shift register as it stood before this cycle, so a clk
  // edge landing together with the load edge never contributes to the latched frame.
  assign capture_ok = load_rise && (bit_cnt_q >= 5'(FRAME_BITS));
  assign cap_addr   = shift_q[ADDR_LSB +: ADDR_W];
  assign cap_data   = shift_q[DATA_LSB +: DATA_W];

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      frame_addr  <= '0;
      frame_data  <= '0;
    end else begin
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      if (load_rise) begin
        bit_cnt_q <= '0;
        if (capture_ok) begin
          frame_valid <= 1'b1;
          frame_addr  <= cap_addr;
          frame_data  <= cap_data;
        end else begin
          frame_err   <= 1'b1;
        end
      end else if (load_lvl) begin
        // Outside the frame window clock edges are ignored and the count stays clear.
        bit_cnt_q <= '0;
      end else if (clk_rise) begin
        shift_q <= {shift_q[FRAME_BITS-2:0], din_sync};
        if (bit_cnt_q != 5'd31) begin
          bit_cnt_q <= bit_cnt_q + 5'd1;
        end
      end
    end
  end

  assign spi_dout = shift_q[FRAME_BITS-1];

`ifdef MAX7219_SHADOW_EN
  logic [7:0] shadow_q [16];

  // Written on the same edge that raises frame_valid, so the new value is readable
  // in the frame_valid cycle itself.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) begin
        shadow_q[i] <= '0;
      end
    end else if (capture_ok && shadow_writable(cap_addr)) begin
      shadow_q[cap_addr] <= cap_data;
    end
  end

  assign rd_data = shadow_q[rd_addr];
`else
  logic unused_rd_addr;
  assign unused_rd_addr = ^rd_addr;
  assign rd_data        = '0;
`endif

endmodule

// File: tb/tb_max7219_frame_receiver.sv
module tb_max7219_frame_receiver;

  localparam int SYNC_STAGES = 2;
  localparam int EXP_LAT     = SYNC_STAGES + 2;
  localparam int HALF        = 4;   // clk cycles per spi_clk phase (period 8)
  localparam int WINDOW      = 20;  // cycles watched after each load rise

`ifdef MAX7219_SHADOW_EN
  localparam bit SHADOW = 1'b1;
`else
  localparam bit SHADOW = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       spi_clk;
  logic       spi_din;
  logic       spi_load;
  logic       spi_dout;
  logic       frame_valid;
  logic       frame_err;
  logic [3:0] frame_addr;
  logic [7:0] frame_data;
  logic [3:0] rd_addr;
  logic [7:0] rd_data;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  max7219_frame_receiver #(.SYNC_STAGES(SYNC_STAGES), .FRAME_BITS(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .spi_clk     (spi_clk),
    .spi_din     (spi_din),
    .spi_load    (spi_load),
    .spi_dout    (spi_dout),
    .frame_valid (frame_valid),
    .frame_err   (frame_err),
    .frame_addr  (frame_addr),
    .frame_data  (frame_data),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data)
  );

  typedef struct {
    int          nbits;
    logic [31:0] stream;     // sent MSB first from bit nbits-1
    bit          coinc;      // extra clk edge coincident with load rise
    logic [3:0]  rd_a;
    bit          exp_valid;
    logic [3:0]  exp_addr;
    logic [7:0]  exp_data;
    logic [7:0]  exp_rd;     // shadow value when the register file is built in
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    spi_din = b;
    spi_clk = 1'b0;
    repeat (HALF) @(negedge clk);
    spi_clk = 1'b1;
    repeat (HALF) @(negedge clk);
  endtask

  // Sends one framed stream, raises load and watches the result window.
  task automatic run_frame(input int nbits, input logic [31:0] stream, input bit coinc,
                           input logic [3:0] rd_a,
                           output int nv, output int ne, output int nboth, output int lat,
                           output logic [7:0] rd_cap, output logic [31:0] dout_obs);
    bit seen;
    nv = 0; ne = 0; nboth = 0; lat = -1; rd_cap = 8'hxx; dout_obs = '0; seen = 1'b0;
    rd_addr  = rd_a;
    spi_load = 1'b0;
    for (int k = 0; k < nbits; k++) begin
      send_bit(stream[nbits-1-k]);
      dout_obs[k] = spi_dout;   // dout after k+1 bits
    end
    spi_din = coinc;
    spi_clk = 1'b0;
    repeat (HALF) @(negedge clk);
    if (coinc) spi_clk = 1'b1;
    spi_load = 1'b1;
    for (int c = 1; c <= WINDOW; c++) begin
      @(posedge clk);
      #1;
      if (frame_valid) begin nv++; rd_cap = rd_data; end
      if (frame_err) ne++;
      if (frame_valid && frame_err) nboth++;
      if ((frame_valid || frame_err) && !seen) begin lat = c; seen = 1'b1; end
    end
    if (nv == 0) rd_cap = rd_data;
    @(negedge clk);
    spi_clk = 1'b0;
  endtask

  task automatic apply_vec(input string tag, input vec_t v);
    int nv, ne, nboth, lat;
    logic [7:0]  rd_cap;
    logic [31:0] dout_obs;
    run_frame(v.nbits, v.stream, v.coinc, v.rd_a, nv, ne, nboth, lat, rd_cap, dout_obs);
    check({tag, "_valid_cnt"}, nv, v.exp_valid ? 1 : 0);
    check({tag, "_err_cnt"},   ne, v.exp_valid ? 0 : 1);
    check({tag, "_both"},      nboth, 0);
    check({tag, "_latency"},   lat, EXP_LAT);
    check({tag, "_addr"},      frame_addr, v.exp_addr);
    check({tag, "_data"},      frame_data, v.exp_data);
    check({tag, "_rd_data"},   rd_cap, SHADOW ? v.exp_rd : 8'h00);
    // After k bits (k >= 16) dout carries stream bit k-16 counted from the first sent.
    for (int k = 16; k <= v.nbits; k++) begin
      check($sformatf("%s_dout_after_%0d", tag, k), dout_obs[k-1], v.stream[v.nbits-1-(k-16)]);
    end
  endtask

  initial begin
    vec_t vecs[6];
    int pulses;

    vecs[0] = '{16, 32'h0000_0C01, 1'b0, 4'hC, 1'b1, 4'hC, 8'h01, 8'h01};
    vecs[1] = '{10, 32'h0000_02AB, 1'b0, 4'hC, 1'b0, 4'hC, 8'h01, 8'h01};
    vecs[2] = '{20, 32'h000B_0A05, 1'b0, 4'hA, 1'b1, 4'hA, 8'h05, 8'h05};
    vecs[3] = '{16, 32'h0000_0355, 1'b1, 4'h3, 1'b1, 4'h3, 8'h55, 8'h55};
    vecs[4] = '{16, 32'h0000_0D33, 1'b0, 4'hD, 1'b1, 4'hD, 8'h33, 8'h00};
    vecs[5] = '{16, 32'h0000_FEAA, 1'b0, 4'hE, 1'b1, 4'hE, 8'hAA, 8'h00};

    rst = 1'b1; spi_clk = 1'b0; spi_din = 1'b0; spi_load = 1'b1; rd_addr = 4'h0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("reset_valid", frame_valid, 1'b0);
    check("reset_err",   frame_err,   1'b0);
    check("reset_addr",  frame_addr,  4'h0);
    check("reset_data",  frame_data,  8'h00);
    check("reset_dout",  spi_dout,    1'b0);
    check("reset_rd",    rd_data,     8'h00);
    pulses = 0;
    for (int c = 0; c < 100; c++) begin
      @(posedge clk);
      #1;
      if (frame_valid || frame_err) pulses++;
    end
    check("idle_pulses", pulses, 0);
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      apply_vec($sformatf("v%0d", i), vecs[i]);
    end

    rd_addr = 4'hC;
    #1;
    check("shadow_c_retained", rd_data, SHADOW ? 8'h01 : 8'h00);
    @(negedge clk);

    // Reset in the middle of a frame: the partial bits are discarded.
    spi_load = 1'b0;
    for (int k = 0; k < 8; k++) send_bit(1'b1);
    spi_clk = 1'b0;
    repeat (HALF) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (HALF) @(negedge clk);
    check("midrst_addr_cleared", frame_addr, 4'h0);
    rd_addr = 4'hC;
    #1;
    check("midrst_shadow_cleared", rd_data, 8'h00);
    apply_vec("midrst", '{16, 32'h0000_0B07, 1'b0, 4'hB, 1'b1, 4'hB, 8'h07, 8'h07});

    // No-op frame: pulses valid but leaves the register file alone.
    apply_vec("noop", '{16, 32'h0000_0000, 1'b0, 4'hB, 1'b1, 4'h0, 8'h00, 8'h07});
    rd_addr = 4'h0;
    #1;
    check("noop_shadow0", rd_data, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
